imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Byte-stream boot loader upstream of the CPU top. It receives a program image over a valid/ready
//  byte channel and writes it word by word into instruction memory through the external port.
//  It then raises cpu_enable to start fetch. It drives addr_ext/wen_ext/ren_ext/wdata_ext/enable.
// PARAMETERS
//  ADDR_W     64   width of addr_ext (matches instruction memory external port)
//  MAX_WORDS  512  max image size in 32-bit words (instruction memory depth)
//  BASE_ADDR  0    byte address of word 0; word k goes to BASE_ADDR + 4*k
// PORTS
//  clk          in   1       main clock
//  arst_n       in   1       reset, synchronous, active-low
//  start        in   1       single-cycle pulse; begin load (honoured only in IDLE)
//  byte_valid   in   1       stream byte valid
//  byte_data    in   8       stream byte
//  byte_ready   out  1       loader accepts byte this cycle
//  addr_ext     out  ADDR_W  instruction memory external address (byte address)
//  wen_ext      out  1       instruction memory external write enable
//  ren_ext      out  1       instruction memory external read enable
//  wdata_ext    out  32      instruction memory external write word
//  rdata_ext    in   32      instruction memory external read word (1-cycle read latency)
//  cpu_enable   out  1       CPU enable; level, stays high once set until reset
//  busy         out  1       high from accepted start until DONE/ERR
//  error        out  1       sticky load error
// BEHAVIOUR
//  - Reset (arst_n==0 at posedge): all outputs 0, FSM=IDLE, counters 0. Partial word/count discarded.
//  - Byte transfer = byte_valid && byte_ready at posedge. byte_ready=1 only in HDR0, HDR1, DATA.
//  - Image format: 2 header bytes = word count N, little-endian (HDR0 low byte, HDR1 high byte).
//    Then 4*N payload bytes, each word little-endian (first byte -> wdata_ext[7:0]).
//  - FSM: IDLE -start-> HDR0 -xfer-> HDR1 -xfer-> CHECK.
//    CHECK: N==0 -> DONE; N>MAX_WORDS -> ERR; else DATA.
//    DATA: byte index b=0..3; on xfer with b==3 -> WRITE.
//    WRITE (1 cycle): wen_ext=1, addr_ext=BASE_ADDR+4*k, wdata_ext=assembled word.
//    Then k++; k==N -> DONE else DATA.
//    DONE: cpu_enable=1, busy=0; terminal until reset. ERR: error=1, busy=0, cpu_enable=0; terminal.
//  - All memory-port outputs registered. wen_ext/ren_ext are never both 1. wen_ext is high exactly
//    one cycle per word. addr_ext/wdata_ext are held stable while wen_ext=1.
//  - Min throughput: 5 cycles/word (4 byte cycles + WRITE); stalls on byte_valid=0 add cycles, no loss.
//  - start outside IDLE ignored. Bytes presented in IDLE/CHECK/WRITE/DONE/ERR are not accepted.
//  - Word counter width $clog2(MAX_WORDS+1); address = BASE_ADDR + {k,2'b00}, zero-extended to ADDR_W.
// CONFIGURATION
//  LOADER_READBACK_EN defined: after each WRITE, go to RD (ren_ext=1, same addr_ext), then CMP.
//    CMP compares rdata_ext with the written word; mismatch -> ERR, match -> DATA/DONE as above.
//    Costs 7 cycles/word minimum.
//  LOADER_READBACK_EN undefined: no RD/CMP states, ren_ext tied 0, rdata_ext unused.
// TESTING
//  1. start, stream 02 00 13 00 00 00 93 00 10 00 -> wen_ext pulses at addr 0 (wdata 0x00000013),
//     then addr 4 (wdata 0x00100093). cpu_enable=1 the cycle after the last WRITE; busy falls.
//  2. Header 00 00 -> no wen_ext pulse; cpu_enable=1 within 2 cycles of HDR1 xfer; error=0.
//  3. Header 01 02 (N=513) -> ERR: error=1, byte_ready=0 thereafter, cpu_enable stays 0.
//  4. N=1 with byte_valid toggling 1/0 each cycle -> exactly one wen_ext pulse, word 0xDDCCBBAA
//     from bytes AA BB CC DD; no byte lost or duplicated.
//  5. Reset asserted after 2 payload bytes, then fresh start + N=1 image 78 56 34 12 ->
//     single write 0x12345678 at addr 0; old bytes discarded.
//  6. (LOADER_READBACK_EN) memory model corrupts bit 0 on read -> error=1 after first word, cpu_enable=0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: receives a length-prefixed program image over a valid/ready byte
// channel, writes it word by word into instruction memory, then enables the CPU.
// Optional feature macro: LOADER_READBACK_EN (read back and verify every written word).
module imem_boot_loader #(
    parameter int unsigned         ADDR_W    = 64,
    parameter int unsigned         MAX_WORDS = 512,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic [ADDR_W-1:0] o_addr_ext,
    output logic              o_wen_ext,
    output logic              o_ren_ext,
    output logic [31:0]       o_wdata_ext,
    input  logic [31:0]       i_rdata_ext,
    output logic              o_cpu_enable,
    output logic              o_busy,
    output logic              o_error
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [3:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StCheck,
        StData,
        StWrite,
        StRd,
        StCmp,
        StDone,
        StErr
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [15:0]        r_nwords;
    logic [CNT_W-1:0]   r_k;
    logic [1:0]         r_bidx;
    logic [31:0]        r_word;
    logic [31:0]        w_word_next;
    logic               w_xfer;
    logic               w_last_word;
    logic               w_inc_k;
    logic               r_wen_ext;
    logic [ADDR_W-1:0]  r_addr_ext;
    logic [31:0]        r_wdata_ext;
    logic               r_cpu_enable;
    logic               r_busy;
    logic               r_error;

    assign o_byte_ready = (r_state == StHdr0) || (r_state == StHdr1) || (r_state == StData);
    assign w_xfer       = i_byte_valid && o_byte_ready;
    assign w_last_word  = (16'(r_k) + 16'd1) == r_nwords;

    // Merge the incoming byte into its little-endian lane of the word being assembled.
    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_bidx, 3'b000} +: 8] = i_byte_data;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; w_inc_k marks the end of one word's write sequence.
    always_comb begin
        w_state_next = r_state;
        w_inc_k      = 1'b0;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StHdr0;
            StHdr0:  if (w_xfer) w_state_next = StHdr1;
            StHdr1:  if (w_xfer) w_state_next = StCheck;
            StCheck: begin
                if (r_nwords == 16'd0) begin
                    w_state_next = StDone;
                end else if (r_nwords > MAX_N) begin
                    w_state_next = StErr;
                end else begin
                    w_state_next = StData;
                end
            end
            StData:  if (w_xfer && (r_bidx == 2'd3)) w_state_next = StWrite;
`ifdef LOADER_READBACK_EN
            StWrite: w_state_next = StRd;
            StRd:    w_state_next = StCmp;
            StCmp: begin
                if (i_rdata_ext != r_wdata_ext) begin
                    w_state_next = StErr;
                end else begin
                    w_inc_k      = 1'b1;
                    w_state_next = w_last_word ? StDone : StData;
                end
            end
`else
            StWrite: begin
                w_inc_k      = 1'b1;
                w_state_next = w_last_word ? StDone : StData;
            end
`endif
            StDone:  w_state_next = StDone;
            StErr:   w_state_next = StErr;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_nwords     <= '0;
            r_k          <= '0;
            r_bidx       <= '0;
            r_word       <= '0;
            r_wen_ext    <= 1'b0;
            r_addr_ext   <= '0;
            r_wdata_ext  <= '0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (r_state == StHdr0 && w_xfer) r_nwords[7:0]  <= i_byte_data;
            if (r_state == StHdr1 && w_xfer) r_nwords[15:8] <= i_byte_data;
            if (r_state == StData && w_xfer) begin
                r_word <= w_word_next;
                r_bidx <= r_bidx + 2'd1;
            end
            if (w_inc_k) r_k <= r_k + CNT_W'(1);
            // Address and data latch once per word and hold through WRITE (and readback).
            if (r_state == StData && w_state_next == StWrite) begin
                r_wdata_ext <= w_word_next;
                r_addr_ext  <= BASE_ADDR + ADDR_W'({r_k, 2'b00});
            end
            r_wen_ext    <= (w_state_next == StWrite);
            r_cpu_enable <= (w_state_next == StDone);
            r_error      <= (w_state_next == StErr);
            r_busy       <= !(w_state_next inside {StIdle, StDone, StErr});
        end
    end

`ifdef LOADER_READBACK_EN
    logic r_ren_ext;

    // Read strobe for the verify cycle, registered like the other memory-port outputs.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_ren_ext <= 1'b0;
        end else begin
            r_ren_ext <= (w_state_next == StRd);
        end
    end

    assign o_ren_ext = r_ren_ext;
`else
    logic w_unused_rdata;

    assign w_unused_rdata = ^i_rdata_ext;
    assign o_ren_ext      = 1'b0;
`endif

    assign o_wen_ext    = r_wen_ext;
    assign o_addr_ext   = r_addr_ext;
    assign o_wdata_ext  = r_wdata_ext;
    assign o_cpu_enable = r_cpu_enable;
    assign o_busy       = r_busy;
    assign o_error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed images, a write-queue model built from the
// image bytes, and a per-cycle monitor comparing every memory write against that model.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned MAX_WORDS = 512;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              start;
    logic              bvalid;
    logic [7:0]        bdata;
    logic              bready;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic              ren;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              cpu_en;
    logic              busy;
    logic              err;

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .BASE_ADDR ('0)
    ) dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_start      (start),
        .i_byte_valid (bvalid),
        .i_byte_data  (bdata),
        .o_byte_ready (bready),
        .o_addr_ext   (addr),
        .o_wen_ext    (wen),
        .o_ren_ext    (ren),
        .o_wdata_ext  (wdata),
        .i_rdata_ext  (rdata),
        .o_cpu_enable (cpu_en),
        .o_busy       (busy),
        .o_error      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory with 1-cycle read latency; corrupt flips bit 0 of read data.
    logic [31:0] mem [0:MAX_WORDS-1];
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (wen) mem[addr[10:2]] <= wdata;
        if (ren) rdata <= mem[addr[10:2]] ^ {31'd0, corrupt};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: expected writes derived directly from the image bytes.
    wr_t exp_q[$];
    wr_t log_q[$];
    wr_t exp_e;
    bit  mon_en        = 1'b0;
    int  last_wen_cyc  = -1;
    int  cpu_first_cyc = -1;

    task automatic model_load(input bq_t img);
        int n;
        n = int'(img[0]) + 256 * int'(img[1]);
        if (n <= int'(MAX_WORDS)) begin
            for (int k = 0; k < n; k++) begin
                exp_q.push_back('{64'(4 * k),
                    {img[4*k+5], img[4*k+4], img[4*k+3], img[4*k+2]}});
            end
        end
    endtask

    // Monitor: every write must match the next expected write; CPU starts only after all writes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wen && ren) begin
                checks++;
                failures++;
                $display("FAIL wen_ren_excl: both high at cycle %0d", cyc);
            end
            if (wen) begin
                log_q.push_back('{addr, wdata});
                last_wen_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                             addr, wdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("wr_addr", addr, exp_e.a);
                    chk("wr_data", 64'(wdata), 64'(exp_e.d));
                end
            end
            if (cpu_en && cpu_first_cyc < 0) begin
                cpu_first_cyc = cyc;
                chk("cpu_en_after_writes", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        start  = 1'b0;
        bvalid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        log_q.delete();
        last_wen_cyc  = -1;
        cpu_first_cyc = -1;
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start, then stream the first 'limit' bytes; returns cycle of the last transfer.
    task automatic send(input bq_t img, input int limit, input bit toggle, output int lx);
        int idx;
        int budget;
        bit x;
        bit ph;
        idx    = 0;
        budget = 0;
        ph     = 1'b0;
        lx     = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        while (idx < limit) begin
            if (budget > 4 * limit + 50) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout: sent %0d of %0d bytes", idx, limit);
                break;
            end
            bvalid = toggle ? ph : 1'b1;
            ph     = ~ph;
            bdata  = img[idx];
            x      = bvalid && bready;
            if (x) lx = cyc;
            @(posedge clk);
            if (x) idx++;
            @(negedge clk);
            budget++;
        end
        bvalid = 1'b0;
    endtask

    bq_t img;
    int  lx;
`ifdef LOADER_READBACK_EN
    localparam int WR_TO_CPU = 3;
`else
    localparam int WR_TO_CPU = 1;
`endif

    initial begin
        arst_n = 1'b0;
        start  = 1'b0;
        bvalid = 1'b0;
        bdata  = 8'h00;
        do_reset();

        // Reset state
        chk("rst_byte_ready", 64'(bready), 64'd0);
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_ren", 64'(ren), 64'd0);
        chk("rst_addr", addr, 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_cpu_en", 64'(cpu_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(err), 64'd0);
        mon_en = 1'b1;

        // 1: two-word image
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        model_load(img);
        send(img, img.size(), 1'b0, lx);
        idle(6);
        chk("t1_nwrites", 64'(log_q.size()), 64'd2);
        if (log_q.size() >= 2) begin
            chk("t1_w0_addr", log_q[0].a, 64'h0);
            chk("t1_w0_data", 64'(log_q[0].d), 64'h0000_0013);
            chk("t1_w1_addr", log_q[1].a, 64'h4);
            chk("t1_w1_data", 64'(log_q[1].d), 64'h0010_0093);
        end
        chk("t1_cpu_latency", 64'(cpu_first_cyc - last_wen_cyc), 64'(WR_TO_CPU));
        chk("t1_cpu_en", 64'(cpu_en), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_error", 64'(err), 64'd0);
        chk("t1_byte_ready", 64'(bready), 64'd0);

        // 2: empty image
        do_reset();
        img = '{8'h00, 8'h00};
        model_load(img);
        send(img, img.size(), 1'b0, lx);
        idle(4);
        chk("t2_hdr_to_cpu_within_2",
            64'((cpu_first_cyc - lx >= 1) && (cpu_first_cyc - lx <= 2)), 64'd1);
        chk("t2_nwrites", 64'(log_q.size()), 64'd0);
        chk("t2_cpu_en", 64'(cpu_en), 64'd1);
        chk("t2_error", 64'(err), 64'd0);

        // 3: oversize image (N = 513)
        do_reset();
        img = '{8'h01, 8'h02};
        model_load(img);
        send(img, img.size(), 1'b0, lx);
        idle(3);
        chk("t3_error", 64'(err), 64'd1);
        chk("t3_cpu_en", 64'(cpu_en), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        bvalid = 1'b1;
        bdata  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            chk("t3_byte_ready_low", 64'(bready), 64'd0);
            @(negedge clk);
        end
        bvalid = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(2);
        chk("t3_start_ignored_err", 64'(err), 64'd1);
        chk("t3_start_ignored_busy", 64'(busy), 64'd0);
        chk("t3_nwrites", 64'(log_q.size()), 64'd0);

        // 4: single word with byte_valid toggling
        do_reset();
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        model_load(img);
        send(img, img.size(), 1'b1, lx);
        idle(6);
        chk("t4_nwrites", 64'(log_q.size()), 64'd1);
        if (log_q.size() >= 1) begin
            chk("t4_w0_addr", log_q[0].a, 64'h0);
            chk("t4_w0_data", 64'(log_q[0].d), 64'hDDCC_BBAA);
        end
        chk("t4_cpu_en", 64'(cpu_en), 64'd1);

        // 5: reset mid-word, then a fresh image
        do_reset();
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        model_load(img);
        send(img, 4, 1'b0, lx);
        do_reset();
        chk("t5_rst_busy", 64'(busy), 64'd0);
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        model_load(img);
        send(img, img.size(), 1'b0, lx);
        idle(6);
        chk("t5_nwrites", 64'(log_q.size()), 64'd1);
        if (log_q.size() >= 1) begin
            chk("t5_w0_addr", log_q[0].a, 64'h0);
            chk("t5_w0_data", 64'(log_q[0].d), 64'h1234_5678);
        end
        chk("t5_cpu_en", 64'(cpu_en), 64'd1);

        // Boundary: N = MAX_WORDS is accepted
        do_reset();
        img = '{8'h00, 8'h02};
        for (int i = 0; i < 4 * int'(MAX_WORDS); i++) img.push_back(8'((i * 7) ^ (i >> 3)));
        model_load(img);
        send(img, img.size(), 1'b0, lx);
        idle(6);
        chk("tmax_nwrites", 64'(log_q.size()), 64'(MAX_WORDS));
        if (log_q.size() == MAX_WORDS) chk("tmax_last_addr", log_q[MAX_WORDS-1].a, 64'h7FC);
        chk("tmax_cpu_en", 64'(cpu_en), 64'd1);
        chk("tmax_error", 64'(err), 64'd0);

`ifdef LOADER_READBACK_EN
        // 6: readback corruption aborts after the first word
        do_reset();
        corrupt = 1'b1;
        img = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        model_load(img);
        send(img, 6, 1'b0, lx);
        idle(6);
        chk("t6_error", 64'(err), 64'd1);
        chk("t6_cpu_en", 64'(cpu_en), 64'd0);
        chk("t6_nwrites", 64'(log_q.size()), 64'd1);
        corrupt = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
